// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the multi-channel memory arbiter interface.
package mem_arb_pkg;

  localparam int MIN_RD_LAT = 1;
  localparam int MAX_RD_LAT = 4;

  // Channel-index width; a single channel still carries a 1-bit index.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int clamp_lat(input int lat);
    if (lat < MIN_RD_LAT) return MIN_RD_LAT;
    if (lat > MAX_RD_LAT) return MAX_RD_LAT;
    return lat;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
// Zero latency; no grant while reset is held low.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_req,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [CH_W-1:0]   o_gnt_idx,
  output logic              o_gnt_vld
);

  logic [CH_W-1:0] r_ptr;
  logic [CH_W-1:0] w_c;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_c       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_c = CH_W'((int'(r_ptr) + i) % NUM_CH);
      if (!o_gnt_vld && i_req[w_c]) begin
        o_gnt_vld  = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_gnt_idx  = w_c;
      end
    end
    if (!i_rst_n) begin
      o_gnt     = '0;
      o_gnt_vld = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (o_gnt_vld) begin
      r_ptr <= CH_W'((int'(o_gnt_idx) + 1) % NUM_CH);
    end
  end

endmodule

// File: rtl/mem_arb_if.sv
// N-channel read/write front end onto one register-file memory, round-robin arbitrated.
// Read data returns RD_LAT cycles after grant; returns are never backpressured.
module mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 4,
  parameter  int RD_LAT = 1,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_read_i,
  input  logic [NUM_CH-1:0]        req_write_i,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  output logic [NUM_CH-1:0]        rd_valid_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [CH_W-1:0]          rd_ch_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LAT   = clamp_lat(RD_LAT);

  typedef struct packed {
    logic              vld;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] dat;
  } rd_pipe_t;

  logic [DATA_W-1:0] r_mem  [DEPTH];
  rd_pipe_t          r_pipe [LAT];

  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_gnt;
  logic [CH_W-1:0]   w_idx;
  logic              w_gnt_vld;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_rd;
  logic              w_wr;
  rd_pipe_t          w_ret;

  assign w_req = req_read_i | req_write_i;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_req     (w_req),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  assign req_ready_o = w_gnt;
  assign w_addr      = req_addr_i[int'(w_idx)*ADDR_W +: ADDR_W];
  assign w_wdata     = req_wdata_i[int'(w_idx)*DATA_W +: DATA_W];
  assign w_rd        = w_gnt_vld & req_read_i[w_idx];
  assign w_wr        = w_gnt_vld & req_write_i[w_idx];

  // A combined read+write returns the data being written this edge.
  always_comb begin
    w_ret     = '0;
    w_ret.vld = w_rd;
    w_ret.ch  = w_idx;
    w_ret.dat = w_wr ? w_wdata : r_mem[w_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  // Payload only moves with a valid so the last stage holds the previous return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < LAT; s++) r_pipe[s] <= '0;
    end else begin
      r_pipe[0].vld <= w_ret.vld;
      if (w_ret.vld) begin
        r_pipe[0].ch  <= w_ret.ch;
        r_pipe[0].dat <= w_ret.dat;
      end
      for (int s = 1; s < LAT; s++) begin
        r_pipe[s].vld <= r_pipe[s-1].vld;
        if (r_pipe[s-1].vld) begin
          r_pipe[s].ch  <= r_pipe[s-1].ch;
          r_pipe[s].dat <= r_pipe[s-1].dat;
        end
      end
    end
  end

  always_comb begin
    rd_valid_o = '0;
    if (r_pipe[LAT-1].vld) rd_valid_o[r_pipe[LAT-1].ch] = 1'b1;
  end

  assign rd_data_o = r_pipe[LAT-1].dat;
  assign rd_ch_o   = r_pipe[LAT-1].ch;

endmodule

// File: tb/tb_mem_arb_if.sv
// Bench for mem_arb_if: directed scenarios plus random traffic against a queue-based model.
module tb_mem_arb_if;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int RD_LAT = 3;
  localparam int DEPTH  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_read_i = '0;
  logic [1:0]  req_write_i = '0;
  logic [7:0]  req_addr_i = '0;
  logic [63:0] req_wdata_i = '0;
  logic [1:0]  req_ready_o;
  logic [1:0]  rd_valid_o;
  logic [31:0] rd_data_o;
  logic [0:0]  rd_ch_o;

  always #5 clk = ~clk;

  mem_arb_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_read_i  (req_read_i),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_ready_o (req_ready_o),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .rd_ch_o     (rd_ch_o)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0]  t_rd = '0, t_wr = '0;
  logic [7:0]  t_addr = '0;
  logic [63:0] t_wdata = '0;

  typedef struct {
    int          due;
    int          ch;
    logic [31:0] dat;
  } ret_t;

  logic [31:0] m_mem [DEPTH];
  int          m_ptr = 0;
  int          cyc = 0;
  ret_t        m_q[$];

  logic [1:0]  e_gnt = '0;
  int          e_idx = -1;
  logic [1:0]  e_rv = '0;
  logic [31:0] e_data = '0;
  int          e_ch = 0;

  logic [1:0]  s_ready, s_rv;
  logic [31:0] s_data;
  logic [0:0]  s_ch;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_ptr = 0;
    m_q.delete();
    e_rv = '0;
    e_data = '0;
    e_ch = 0;
  endfunction

  // Winner is the first requesting channel at or after the pointer.
  function automatic void model_grant();
    int c;
    e_gnt = '0;
    e_idx = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (m_ptr + k) % NUM_CH;
      if (e_idx < 0 && (t_rd[c] | t_wr[c])) begin
        e_idx = c;
        e_gnt[c] = 1'b1;
      end
    end
  endfunction

  function automatic void model_edge();
    logic [3:0]  a;
    logic [31:0] w, old;
    cyc++;
    if (e_idx >= 0) begin
      a = t_addr[e_idx*4 +: 4];
      w = t_wdata[e_idx*32 +: 32];
      old = m_mem[a];
      if (t_wr[e_idx]) m_mem[a] = w;
      if (t_rd[e_idx]) m_q.push_back('{cyc + RD_LAT - 1, e_idx, t_wr[e_idx] ? w : old});
      m_ptr = (e_idx + 1) % NUM_CH;
    end
    e_rv = '0;
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      e_rv[m_q[0].ch] = 1'b1;
      e_data = m_q[0].dat;
      e_ch = m_q[0].ch;
      void'(m_q.pop_front());
    end
  endfunction

  task automatic cycle();
    @(negedge clk);
    req_read_i  = t_rd;
    req_write_i = t_wr;
    req_addr_i  = t_addr;
    req_wdata_i = t_wdata;
    #1;
    model_grant();
    s_ready = req_ready_o;
    s_rv    = rd_valid_o;
    s_data  = rd_data_o;
    s_ch    = rd_ch_o;
    chk("ready", s_ready, e_gnt);
    chk("rd_valid", s_rv, e_rv);
    chk("rd_data", s_data, e_data);
    chk("rd_ch", s_ch, e_ch);
    @(posedge clk);
    model_edge();
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    req_read_i = 2'b11;
    req_write_i = 2'b00;
    model_reset();
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_ready", req_ready_o, 2'b00);
      chk("rst_rd_valid", rd_valid_o, 2'b00);
      chk("rst_rd_data", rd_data_o, 32'h0);
      chk("rst_rd_ch", rd_ch_o, 1'b0);
      @(negedge clk);
    end
    #1;
    reset = 1'b1;
    req_read_i = '0;
    t_rd = '0; t_wr = '0; t_addr = '0; t_wdata = '0;
  endtask

  task automatic idle_until_ret(output logic [1:0] rv, output logic [31:0] dat, output int cnt);
    rv = '0; dat = '0; cnt = 0;
    t_rd = '0; t_wr = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_rv != 0) begin
        cnt++;
        if (rv == 0) begin
          rv = s_rv;
          dat = s_data;
        end
      end
    end
  endtask

  initial begin
    int          n, c0, c1, cnt, k;
    logic [1:0]  g1, g2, rv;
    logic [31:0] dat;
    bit          pend [NUM_CH];
    logic        pr [NUM_CH], pw [NUM_CH];
    logic [3:0]  pa [NUM_CH];
    logic [31:0] pd [NUM_CH];

    apply_reset(2);

    // Write then read back on channel 0, measuring the return latency.
    t_wr = 2'b01; t_addr = 8'h03; t_wdata = 64'hDEADBEEF;
    cycle();
    chk("t1_wr_ready", s_ready, 2'b01);
    t_wr = 2'b00; t_rd = 2'b01;
    cycle();
    chk("t1_rd_ready", s_ready, 2'b01);
    t_rd = 2'b00;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (n == 0 && s_rv != 0) begin
        n = i;
        chk("t1_rv", s_rv, 2'b01);
        chk("t1_data", s_data, 32'hDEADBEEF);
        chk("t1_ch", s_ch, 1'b0);
      end
    end
    chk("t1_latency", n, RD_LAT);

    // Both channels read continuously: grants alternate, 8 tagged returns.
    apply_reset(1);
    t_rd = 2'b11; t_addr = 8'h00;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t2_grant", s_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (s_rv == 2'b01) c0++;
      if (s_rv == 2'b10) c1++;
    end
    t_rd = 2'b00;
    repeat (RD_LAT + 2) begin
      cycle();
      if (s_rv == 2'b01) c0++;
      if (s_rv == 2'b10) c1++;
    end
    chk("t2_ret_ch0", c0, 4);
    chk("t2_ret_ch1", c1, 4);

    // Simultaneous writes to one address: ch0 first, ch1's value survives.
    apply_reset(1);
    t_wr = 2'b11; t_addr = 8'h55; t_wdata = {32'h22, 32'h11};
    cycle();
    g1 = s_ready;
    t_wr = 2'b10;
    cycle();
    g2 = s_ready;
    chk("t3_first_grant", g1, 2'b01);
    chk("t3_second_grant", g2, 2'b10);
    t_wr = 2'b00; t_rd = 2'b01; t_addr = 8'h05;
    cycle();
    idle_until_ret(rv, dat, cnt);
    chk("t3_rv", rv, 2'b01);
    chk("t3_data", dat, 32'h22);

    // Read+write together on ch1: one grant, write-through data.
    t_rd = 2'b10; t_wr = 2'b10; t_addr = 8'h70; t_wdata = {32'h0000A5A5, 32'h0};
    cycle();
    chk("t4_ready", s_ready, 2'b10);
    idle_until_ret(rv, dat, cnt);
    chk("t4_rv", rv, 2'b10);
    chk("t4_data", dat, 32'hA5A5);
    chk("t4_one_return", cnt, 1);
    t_rd = 2'b01; t_addr = 8'h07;
    cycle();
    idle_until_ret(rv, dat, cnt);
    chk("t4_mem_holds", dat, 32'hA5A5);

    // Reset with a read in flight: it never returns and memory is cleared.
    t_wr = 2'b01; t_addr = 8'h02; t_wdata = 64'h77;
    cycle();
    t_wr = 2'b00; t_rd = 2'b01;
    cycle();
    apply_reset(2);
    idle_until_ret(rv, dat, cnt);
    chk("t5_no_return", cnt, 0);
    t_rd = 2'b01; t_addr = 8'h02;
    cycle();
    idle_until_ret(rv, dat, cnt);
    chk("t5_rv", rv, 2'b01);
    chk("t5_data", dat, 32'h0);

    // Never-written top address reads as zero.
    t_rd = 2'b10; t_addr = 8'hF0;
    cycle();
    idle_until_ret(rv, dat, cnt);
    chk("t6_rv", rv, 2'b10);
    chk("t6_data", dat, 32'h0);

    // Random traffic; requests hold until granted, occasionally withdrawn.
    apply_reset(1);
    for (int c = 0; c < NUM_CH; c++) begin
      pend[c] = 1'b0; pr[c] = 1'b0; pw[c] = 1'b0; pa[c] = '0; pd[c] = '0;
    end
    for (int it = 0; it < 3000; it++) begin
      if (it % 700 == 699) begin
        apply_reset(1);
        for (int c = 0; c < NUM_CH; c++) pend[c] = 1'b0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (pend[c] && $urandom_range(0, 31) == 0) begin
          pend[c] = 1'b0;
        end else if (!pend[c] && $urandom_range(0, 1) == 1) begin
          pend[c] = 1'b1;
          k = $urandom_range(1, 3);
          pr[c] = k[0];
          pw[c] = k[1];
          pa[c] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
          pd[c] = $urandom;
        end
        t_rd[c] = pend[c] && pr[c];
        t_wr[c] = pend[c] && pw[c];
        t_addr[c*4 +: 4] = pa[c];
        t_wdata[c*32 +: 32] = pd[c];
      end
      cycle();
      if (e_idx >= 0) pend[e_idx] = 1'b0;
    end
    t_rd = '0; t_wr = '0;
    repeat (RD_LAT + 2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
